countdown_timer_sync: RTL and testbench
=======================================

COUNTDOWN_TIMER_SYNC -- requirements
Module: countdown_timer_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 Port Clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port Reset_n  input  1  is the reset; it SHALL be synchronous and active-low.
REQ-004 Port Load  input  1  SHALL request a load of LoadValue.
REQ-005 Port LoadValue  input  WIDTH  SHALL carry the start value sampled when Load=1.
REQ-006 Port Enable  input  1  SHALL permit one decrement per cycle while running.
REQ-007 Port Count  output  WIDTH  SHALL expose the current registered count.
REQ-008 Port Busy  output  1  SHALL be high while in state RUN.
REQ-009 Port Done  output  1  SHALL be a registered one-cycle pulse marking terminal count.
REQ-010 Port Zero  output  1  SHALL equal (Count == 0), combinational from Count.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE, encoded as a package enum.
REQ-012 Load=1 with LoadValue!=0 SHALL set Count=LoadValue and latch LoadValue into a reload register at that edge, then enter RUN, in any state.
REQ-013 Load=1 with LoadValue==0 SHALL set Count=0, enter IDLE, and produce no Done pulse.
REQ-014 Load SHALL take priority over Enable on the same edge; no decrement occurs on a load edge.
REQ-015 In RUN with Enable=1 and Load=0, Count SHALL decrement by exactly 1 per edge; Enable=0 SHALL hold Count.
REQ-016 In RUN, a decrement from Count=1 SHALL make Count=0, enter DONE, and assert Done for the following cycle only.
REQ-017 DONE SHALL last exactly one cycle and then go to IDLE unless Load=1 on that edge.
REQ-018 In IDLE or DONE, Enable SHALL have no effect; Count SHALL never wrap from 0 to all-ones.
REQ-019 Latency: with a load at edge N of value V and Enable held high, Count SHALL read V-k after edge N+k, and Done SHALL be high in the cycle after edge N+V.
REQ-020 Busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.

Reset
REQ-021 Reset_n=0 at a rising edge SHALL force IDLE, Count=0, reload register=0, Done=0 and Busy=0, overriding Load and Enable.
REQ-022 Reset in mid-count SHALL abort the count with no Done pulse.
REQ-023 The block SHALL contain no initial blocks and no asynchronous reset paths.

Configuration
REQ-024 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select periodic mode.
  - Defined: a decrement from 1 SHALL load Count from the reload register, pulse Done for one cycle, and stay in RUN (Busy stays 1).
  - Undefined: REQ-016 and REQ-017 apply, and the reload register SHALL be omitted.

Structure
REQ-025 Package countdown_timer_pkg SHALL hold the state enum and the WIDTH default constant.
REQ-026 The datapath SHALL be one sub-module, countdown_core (load/hold/decrement register plus Zero compare), instantiated under the FSM.

Verification
REQ-027 Reset: Reset_n=0 for 2 cycles with Load=1 and LoadValue=9 -> Count=0, Busy=0, Done=0.
REQ-028 Basic count: load 5 with Enable high -> Count reads 5,4,3,2,1,0 on successive cycles, Done is high for one cycle after the 1->0 edge, and the block returns to IDLE.
REQ-029 Enable gaps: load 3, Enable pattern 1,0,0,1,1 -> Count reads 3,2,2,2,1,0 and Done arrives 2 cycles later than in the no-gap case.
REQ-030 Reload and zero-load: Load 7 while Count=2 in RUN -> Count=7 and no Done; Load 0 -> IDLE with Count=0, Zero=1 and no Done.
REQ-031 Reset mid-run: Reset_n=0 at Count=4 -> Count=0 and IDLE next cycle, with no Done pulse.
REQ-032 Auto-reload (macro defined): load 2 with Enable high -> Count reads 2,1,2,1,... and Done pulses every 2 cycles while Busy stays 1.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_timer_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_sync_if.sv
// Command/status bundle for countdown_timer_sync, with the FSM state exposed for observation.
interface countdown_timer_sync_if
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();
    // No valid/ready pair: Load is a single-cycle command accepted unconditionally at
    // the edge where it is high, and Enable is a level qualifier sampled every edge.
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic             Enable;
    logic [WIDTH-1:0] Count;
    logic             Busy;
    logic             Done;
    logic             Zero;
    state_e           State;

    modport master (
        output Load, LoadValue, Enable,
        input  Count, Busy, Done, Zero, State
    );

    modport slave (
        input  Load, LoadValue, Enable,
        output Count, Busy, Done, Zero, State
    );
endinterface

// File: rtl/countdown_core.sv
// Count register: load, hold or decrement, saturating at zero, plus the zero compare.
module countdown_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dec_en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_en) begin
            count_d = load_data;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
endmodule

// File: rtl/countdown_timer_sync.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle Done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode (reload from the last loaded value).
module countdown_timer_sync
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    countdown_timer_sync_if.slave  bus
);
    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             core_load;
    logic [WIDTH-1:0] core_load_data;
    logic             core_dec;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             at_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    assign at_one = (count == WIDTH'(1));

    always_comb begin
        state_d        = state_q;
        done_d         = 1'b0;
        core_load      = 1'b0;
        core_load_data = bus.LoadValue;
        core_dec       = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d       = reload_q;
`endif
        // A load wins over everything else and never decrements on its own edge.
        if (bus.Load) begin
            core_load = 1'b1;
            if (bus.LoadValue != '0) begin
                state_d = ST_RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                reload_d = bus.LoadValue;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.Enable) begin
                        if (at_one) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            core_load      = 1'b1;
                            core_load_data = reload_q;
`else
                            core_dec = 1'b1;
                            state_d  = ST_DONE;
`endif
                        end else begin
                            core_dec = 1'b1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    countdown_core #(.WIDTH(WIDTH)) u_core (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .load_en   (core_load),
        .load_data (core_load_data),
        .dec_en    (core_dec),
        .count     (count),
        .zero      (zero)
    );

    assign bus.Count = count;
    assign bus.Zero  = zero;
    assign bus.Busy  = (state_q == ST_RUN);
    assign bus.Done  = done_q;
    assign bus.State = state_q;
endmodule

// File: tb/tb_countdown_timer_sync.sv
// Bench for countdown_timer_sync: directed vector table, then random traffic vs a reference model.
module tb_countdown_timer_sync;
    import countdown_timer_pkg::*;

    localparam int WIDTH = WIDTH_DEFAULT;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_sync_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer_sync #(.WIDTH(WIDTH)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a number that counts down, and a running flag.
    int m_count   = 0;
    int m_reload  = 0;
    bit m_running = 1'b0;
    bit m_done    = 1'b0;

    typedef struct {
        bit rst_n;
        bit load;
        int lv;
        bit en;
        int count;
        bit busy;
        bit done;
        bit zero;
    } vec_t;

    vec_t vecs[$];

    task automatic model_step(input bit r, input bit ld, input int lv, input bit en);
        bit done_next;
        if (!r) begin
            m_count   = 0;
            m_reload  = 0;
            m_running = 1'b0;
            m_done    = 1'b0;
        end else begin
            done_next = 1'b0;
            if (ld) begin
                m_count   = lv;
                m_running = (lv != 0);
                if (lv != 0) m_reload = lv;
            end else if (m_running && en) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    done_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    m_count = m_reload;
`else
                    m_running = 1'b0;
`endif
                end
            end
            m_done = done_next;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input int lv, input bit en);
        @(negedge clk);
        rst_n         = r;
        bus.Load      = ld;
        bus.LoadValue = WIDTH'(lv);
        bus.Enable    = en;
        @(posedge clk);
        model_step(r, ld, lv, en);
        #1;
    endtask

    function automatic int exp_state(input bit busy, input bit done);
        if (busy)      return int'(ST_RUN);
        else if (done) return int'(ST_DONE);
        else           return int'(ST_IDLE);
    endfunction

    task automatic add(input bit r, input bit ld, input int lv, input bit en,
                       input int c, input bit b, input bit d, input bit z);
        vec_t v;
        v = '{rst_n: r, load: ld, lv: lv, en: en, count: c, busy: b, done: d, zero: z};
        vecs.push_back(v);
    endtask

    initial begin
        bus.Load      = 1'b1;
        bus.LoadValue = WIDTH'(9);
        bus.Enable    = 1'b1;

        // Reset held two cycles while Load=1, LoadValue=9
        add(0, 1, 9, 1,  0, 0, 0, 1);
        add(0, 1, 9, 1,  0, 0, 0, 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Periodic: 2,1,2,1 with Done after each 1->reload edge
        add(1, 1, 2, 1,  2, 1, 0, 0);
        add(1, 0, 0, 1,  1, 1, 0, 0);
        add(1, 0, 0, 1,  2, 1, 1, 0);
        add(1, 0, 0, 1,  1, 1, 0, 0);
        add(1, 0, 0, 1,  2, 1, 1, 0);
        add(1, 0, 0, 0,  2, 1, 0, 0);
        add(1, 0, 0, 1,  1, 1, 0, 0);
        add(1, 0, 0, 1,  2, 1, 1, 0);
        add(1, 1, 0, 1,  0, 0, 0, 1);
        add(1, 0, 0, 1,  0, 0, 0, 1);
`else
        // Load 5, Enable high: 5..0, Done one cycle, back to IDLE
        add(1, 1, 5, 1,  5, 1, 0, 0);
        add(1, 0, 0, 1,  4, 1, 0, 0);
        add(1, 0, 0, 1,  3, 1, 0, 0);
        add(1, 0, 0, 1,  2, 1, 0, 0);
        add(1, 0, 0, 1,  1, 1, 0, 0);
        add(1, 0, 0, 1,  0, 0, 1, 1);
        add(1, 0, 0, 1,  0, 0, 0, 1);
        add(1, 0, 0, 1,  0, 0, 0, 1);
        // Enable gaps: load 3 then 1,0,0,1,1
        add(1, 1, 3, 0,  3, 1, 0, 0);
        add(1, 0, 0, 1,  2, 1, 0, 0);
        add(1, 0, 0, 0,  2, 1, 0, 0);
        add(1, 0, 0, 0,  2, 1, 0, 0);
        add(1, 0, 0, 1,  1, 1, 0, 0);
        add(1, 0, 0, 1,  0, 0, 1, 1);
        add(1, 0, 0, 0,  0, 0, 0, 1);
        // Reload 7 at Count=2, then load 0
        add(1, 1, 5, 1,  5, 1, 0, 0);
        add(1, 0, 0, 1,  4, 1, 0, 0);
        add(1, 0, 0, 1,  3, 1, 0, 0);
        add(1, 0, 0, 1,  2, 1, 0, 0);
        add(1, 1, 7, 1,  7, 1, 0, 0);
        add(1, 0, 0, 1,  6, 1, 0, 0);
        add(1, 1, 0, 1,  0, 0, 0, 1);
        add(1, 0, 0, 1,  0, 0, 0, 1);
        // Reset at Count=4
        add(1, 1, 6, 1,  6, 1, 0, 0);
        add(1, 0, 0, 1,  5, 1, 0, 0);
        add(1, 0, 0, 1,  4, 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 1);
        add(1, 0, 0, 1,  0, 0, 0, 1);
        // Load in the DONE cycle restarts without decrementing
        add(1, 1, 2, 1,  2, 1, 0, 0);
        add(1, 0, 0, 1,  1, 1, 0, 0);
        add(1, 0, 0, 1,  0, 0, 1, 1);
        add(1, 1, 1, 1,  1, 1, 0, 0);
        add(1, 0, 0, 1,  0, 0, 1, 1);
        add(1, 0, 0, 0,  0, 0, 0, 1);
        // Maximum load value
        add(1, 1, MAXV, 0,  MAXV, 1, 0, 0);
        add(1, 0, 0, 1,  MAXV - 1, 1, 0, 0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].load, vecs[i].lv, vecs[i].en);
            check($sformatf("vec%0d_count", i), int'(bus.Count), vecs[i].count);
            check($sformatf("vec%0d_busy", i),  int'(bus.Busy),  int'(vecs[i].busy));
            check($sformatf("vec%0d_done", i),  int'(bus.Done),  int'(vecs[i].done));
            check($sformatf("vec%0d_zero", i),  int'(bus.Zero),  int'(vecs[i].zero));
            check($sformatf("vec%0d_state", i), int'(bus.State),
                  exp_state(vecs[i].busy, vecs[i].done));
        end

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bit r, ld, en;
            int lv;
            r  = ($urandom_range(0, 59) != 0);
            ld = ($urandom_range(0, 9) == 0);
            lv = (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, MAXV)));
            en = ($urandom_range(0, 3) != 0);
            drive(r, ld, lv, en);
            check($sformatf("rnd%0d_count", i), int'(bus.Count), m_count);
            check($sformatf("rnd%0d_busy", i),  int'(bus.Busy),  int'(m_running));
            check($sformatf("rnd%0d_done", i),  int'(bus.Done),  int'(m_done));
            check($sformatf("rnd%0d_zero", i),  int'(bus.Zero),  int'(m_count == 0));
            check($sformatf("rnd%0d_state", i), int'(bus.State), exp_state(m_running, m_done));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
